// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed seven-segment scanner.
// Segment bus and digit anodes are active low; digit 0 is the units digit.
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  blank_lz,
    output logic [6:0]            disp,
    output logic [DIGITS-1:0]     mux,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    seg_glyph = 7'b1000000;
            4'd1:    seg_glyph = 7'b1111001;
            4'd2:    seg_glyph = 7'b0100100;
            4'd3:    seg_glyph = 7'b0110000;
            4'd4:    seg_glyph = 7'b0011001;
            4'd5:    seg_glyph = 7'b0010010;
            4'd6:    seg_glyph = 7'b0000010;
            4'd7:    seg_glyph = 7'b1111000;
            4'd8:    seg_glyph = 7'b0000000;
            4'd9:    seg_glyph = 7'b0010000;
            default: seg_glyph = 7'b1111111;
        endcase
    endfunction

    logic [TW-1:0]          tick_cnt_r;
    logic [SW-1:0]          scan_cnt_r;
    logic [IW-1:0]          scan_idx_r;
    logic [4*DIGITS-1:0]    value_r;
    logic [4*DIGITS-1:0]    value_nxt_s;
    logic                   wrap_r;
    logic                   carry_s;
    logic                   tick_s;
    logic [DIGITS-1:0]      zero_above_s;
    logic [3:0]             cur_digit_s;
    logic                   cur_zero_s;
    logic                   blank_s;
    logic [6:0]             disp_r;
    logic [DIGITS-1:0]      mux_r;

    assign tick_s = en && (tick_cnt_r == TICK_LAST);
    assign value  = value_r;
    assign wrap   = wrap_r;
    assign disp   = disp_r;
    assign mux    = mux_r;

    // Ripple the +1/-1 step through the digits; carry_s leaving the top digit is a wrap.
    always_comb begin
        carry_s     = 1'b1;
        value_nxt_s = value_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (!carry_s) begin
                value_nxt_s[4*i +: 4] = value_r[4*i +: 4];
            end else if (up) begin
                if (value_r[4*i +: 4] >= 4'd9) begin
                    value_nxt_s[4*i +: 4] = 4'd0;
                    carry_s               = 1'b1;
                end else begin
                    value_nxt_s[4*i +: 4] = value_r[4*i +: 4] + 4'd1;
                    carry_s               = 1'b0;
                end
            end else begin
                if (value_r[4*i +: 4] == 4'd0) begin
                    value_nxt_s[4*i +: 4] = 4'd9;
                    carry_s               = 1'b1;
                end else begin
                    value_nxt_s[4*i +: 4] = value_r[4*i +: 4] - 4'd1;
                    carry_s               = 1'b0;
                end
            end
        end
    end

    // Select the scanned digit and decide whether it is a leading zero to blank.
    always_comb begin
        zero_above_s           = '0;
        zero_above_s[DIGITS-1] = (value_r[4*DIGITS-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_above_s[i] = (value_r[4*i +: 4] == 4'd0) && zero_above_s[i+1];
        end
        cur_digit_s = 4'd0;
        cur_zero_s  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            cur_digit_s = (scan_idx_r == IW'(i)) ? value_r[4*i +: 4] : cur_digit_s;
            cur_zero_s  = (scan_idx_r == IW'(i)) ? zero_above_s[i]   : cur_zero_s;
        end
        blank_s = blank_lz && (scan_idx_r != '0) && cur_zero_s;
    end

    // Count prescaler, BCD value and wrap pulse; clr beats a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
            value_r    <= '0;
            wrap_r     <= 1'b0;
        end else if (clr) begin
            tick_cnt_r <= '0;
            value_r    <= '0;
            wrap_r     <= 1'b0;
        end else begin
            wrap_r <= tick_s && carry_s;
            if (tick_s) begin
                value_r <= value_nxt_s;
            end
            if (en) begin
                tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
            end
        end
    end

    // Free-running scan prescaler and digit index, untouched by en and clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= '0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            scan_idx_r <= (scan_idx_r == IDX_LAST) ? '0 : scan_idx_r + IW'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // Registered anode and segment drive, one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_r  <= ~DIGITS'(1);
            disp_r <= 7'b1000000;
        end else begin
            mux_r  <= ~(DIGITS'(1) << scan_idx_r);
            disp_r <= blank_s ? 7'b1111111 : seg_glyph(cur_digit_s);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4, TICK_DIV=4, SCAN_DIV=2) with a
// queue scoreboard: expectations are queued with the stimulus, popped at the check.
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, clr, blank_lz;
    logic [6:0]  disp;
    logic [3:0]  mux;
    logic [15:0] value;
    logic        wrap;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [3:0] mux_pat[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] disp_bl[4] = '{7'b1111000, 7'b0110000, 7'b1111111, 7'b1111111};
    logic [6:0] disp_nb[4] = '{7'b1111000, 7'b0110000, 7'b1000000, 7'b1000000};

    bcd_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .blank_lz(blank_lz),
        .disp(disp), .mux(mux), .value(value), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts and ends with the count prescaler at 0, so exactly n ticks occur.
    task automatic step_ticks(input int n);
        en = 1'b1;
        cyc(4 * n);
        en = 1'b0;
    endtask

    task automatic measure_gap(output int gap);
        logic [15:0] v0;
        v0  = value;
        gap = 0;
        en  = 1'b1;
        while (value === v0 && gap < 40) begin
            cyc(1);
            gap++;
        end
        en = 1'b0;
    endtask

    // Stops on the first cycle that mux shows digit 0 after digit 3.
    task automatic sync_digit0(output logic found);
        logic [3:0] prev;
        found = 1'b0;
        prev  = mux;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(1);
            if (mux === 4'b1110 && prev === 4'b0111) found = 1'b1;
            else prev = mux;
        end
    endtask

    initial begin
        int   gap;
        logic found;
        logic changed;
        logic [15:0] held;

        rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; blank_lz = 1'b0;
        cyc(2);
        rst = 1'b0;
        expect_push("reset_value", 32'h0000); check_pop(32'(value));
        expect_push("reset_mux",   32'h000E); check_pop(32'(mux));
        expect_push("reset_disp",  32'h0040); check_pop(32'(disp));
        expect_push("reset_wrap",  32'h0000); check_pop(32'(wrap));

        expect_push("up_0009", 32'h0009);
        step_ticks(9);
        check_pop(32'(value));
        expect_push("carry_0010", 32'h0010);
        expect_push("tick_gap",   32'd4);
        measure_gap(gap);
        check_pop(32'(value));
        check_pop(32'(gap));

        expect_push("up_0999", 32'h0999);
        step_ticks(989);
        check_pop(32'(value));
        expect_push("carry_1000", 32'h1000);
        step_ticks(1);
        check_pop(32'(value));

        up = 1'b0;
        expect_push("borrow_0999", 32'h0999);
        step_ticks(1);
        check_pop(32'(value));

        clr = 1'b1; cyc(1); clr = 1'b0;
        expect_push("clr_value", 32'h0000); check_pop(32'(value));

        expect_push("down_wrap_value", 32'h9999);
        expect_push("down_wrap_pulse", 32'h1);
        step_ticks(1);
        check_pop(32'(value));
        check_pop(32'(wrap));
        expect_push("down_wrap_end", 32'h0);
        cyc(1);
        check_pop(32'(wrap));

        up = 1'b1;
        expect_push("up_wrap_value", 32'h0000);
        expect_push("up_wrap_pulse", 32'h1);
        step_ticks(1);
        check_pop(32'(value));
        check_pop(32'(wrap));
        expect_push("up_wrap_end", 32'h0);
        cyc(1);
        check_pop(32'(wrap));

        expect_push("up_0042", 32'h0042);
        step_ticks(42);
        check_pop(32'(value));
        en = 1'b1;
        cyc(3);
        expect_push("pre_tick_0042", 32'h0042); check_pop(32'(value));
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        expect_push("collide_value", 32'h0000); check_pop(32'(value));
        expect_push("collide_wrap",  32'h0);    check_pop(32'(wrap));
        expect_push("after_clr_value", 32'h0001);
        expect_push("after_clr_gap",   32'd4);
        measure_gap(gap);
        check_pop(32'(value));
        check_pop(32'(gap));

        held    = value;
        changed = 1'b0;
        expect_push("freeze_changed", 32'h0);
        expect_push("freeze_value",   32'h0001);
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (value !== held) changed = 1'b1;
        end
        check_pop(32'(changed));
        check_pop(32'(value));

        clr = 1'b1; cyc(1); clr = 1'b0;
        expect_push("up_0037", 32'h0037);
        step_ticks(37);
        check_pop(32'(value));

        blank_lz = 1'b1;
        expect_push("sync_blank", 32'h1);
        sync_digit0(found);
        check_pop(32'(found));
        for (int k = 0; k < 8; k++) begin
            expect_push($sformatf("scan_bl_mux%0d", k),  32'(mux_pat[k/2]));
            expect_push($sformatf("scan_bl_disp%0d", k), 32'(disp_bl[k/2]));
            check_pop(32'(mux));
            check_pop(32'(disp));
            cyc(1);
        end

        blank_lz = 1'b0;
        expect_push("sync_noblank", 32'h1);
        sync_digit0(found);
        check_pop(32'(found));
        for (int k = 0; k < 8; k++) begin
            expect_push($sformatf("scan_nb_mux%0d", k),  32'(mux_pat[k/2]));
            expect_push($sformatf("scan_nb_disp%0d", k), 32'(disp_nb[k/2]));
            check_pop(32'(mux));
            check_pop(32'(disp));
            cyc(1);
        end

        clr = 1'b1; cyc(1); clr = 1'b0;
        expect_push("up_1234", 32'h1234);
        step_ticks(1234);
        check_pop(32'(value));
        expect_push("sync_mid", 32'h1);
        sync_digit0(found);
        check_pop(32'(found));
        cyc(3);
        expect_push("mid_pre_mux", 32'h000D); check_pop(32'(mux));
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        expect_push("mid_rst_value", 32'h0000); check_pop(32'(value));
        expect_push("mid_rst_mux",   32'h000E); check_pop(32'(mux));
        expect_push("mid_rst_wrap",  32'h0);    check_pop(32'(wrap));
        expect_push("mid_rst_disp",  32'h0040); check_pop(32'(disp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Parametrised multi-digit BCD up/down counter with an integrated seven-segment time-multiplexed scanner.
- Generalises the single-digit counter, decoder and four-way mux arrangement into one block of DIGITS digits.
- Adds count direction, enable, synchronous clear, leading-zero blanking and a wrap pulse.
- Drives the board's shared segment bus and digit anodes directly from the top level.

Parameters:
- DIGITS, 4: number of BCD digits counted and scanned (1..8).
- TICK_DIV, 50_000_000: clk cycles per count step.
- SCAN_DIV, 100_000: clk cycles per digit dwell time during scanning.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; gates the count prescaler.
- up  input  1  1 = increment, 0 = decrement; sampled on each tick.
- clr  input  1  synchronous clear of the count value.
- blank_lz  input  1  1 = blank leading zero digits.
- disp  output  7  segments {g,f,e,d,c,b,a}, active low.
- mux  output  DIGITS  digit anodes, one-hot active low; bit 0 = units.
- value  output  4*DIGITS  packed BCD count; [3:0] = units.
- wrap  output  1  one-cycle pulse on a count overflow or underflow.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset state:
  - value = 0, wrap = 0.
  - Both prescalers = 0, scan index = 0.
  - mux = ~1 (digit 0 on).
  - disp = 7'b1000000 (glyph "0").
- Count prescaler:
  - Counts 0..TICK_DIV-1 while en = 1; holds its value while en = 0.
  - tick = 1 for one cycle when the prescaler = TICK_DIV-1 and en = 1; the prescaler then returns to 0.
- Count step on tick:
  - up = 1: units digit +1. A digit at 9 goes to 0 and carries into the next digit.
  - up = 0: units digit -1. A digit at 0 goes to 9 and borrows from the next digit.
  - All digits stay in 0..9 at all times.
- Wrap:
  - All 9s incrementing goes to all 0s with wrap = 1 on the following cycle.
  - All 0s decrementing goes to all 9s with wrap = 1 on the following cycle.
  - wrap is registered and lasts exactly one cycle.
- clr:
  - value goes to 0 next cycle and the count prescaler resets to 0.
  - clr takes priority over a simultaneous tick; no wrap is produced.
  - clr does not affect the scan logic.
- value is registered; it updates in the cycle after tick.
- Scan prescaler:
  - Free-running 0..SCAN_DIV-1, independent of en and clr.
  - At terminal count, scan index advances 0→1→…→DIGITS-1→0.
- disp and mux are registered from the current scan index and value. They change exactly one cycle after the scan index changes.
- Glyph table (active low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Leading-zero blanking:
  - With blank_lz = 1, digit i (i ≥ 1) is blanked when it and all higher digits are 0.
  - A blanked digit drives disp = 7'b1111111; its mux bit is still driven low.
  - Digit 0 is never blanked.
- DIGITS = 1: the scan index stays at 0 and mux is constantly 0.
- rst asserted mid-scan or mid-count restores the full reset state on the next edge.

Test Plan:
Bench configuration: DIGITS = 4, TICK_DIV = 4, SCAN_DIV = 2.
- Reset:
  - Stimulus: assert rst for 2 cycles, then release.
  - Required: value = 0x0000, mux = 4'b1110, disp = 1000000, wrap = 0.
- Up count with carry:
  - Stimulus: en = 1, up = 1 from value 0x0009; one tick.
  - Required: value = 0x0010. From 0x0999 → 0x1000.
  - Required: exactly 4 cycles between value changes.
- Wrap both directions:
  - Up: 0x9999 + tick → 0x0000 with a single-cycle wrap pulse.
  - Down: from 0x0000 with up = 0 + tick → 0x9999 with a single-cycle wrap pulse.
- clr/tick collision:
  - Stimulus: assert clr on the tick cycle at value 0x0042.
  - Required: value = 0x0000, wrap stays 0; the next tick occurs 4 cycles after clr.
  - Also check: en = 0 freezes value for 20 cycles.
- Scan and blanking:
  - Stimulus: value 0x0037, blank_lz = 1.
  - Required: mux cycles 1110 → 1101 → 1011 → 0111, each step lasting 2 cycles.
  - Required: disp = 1111000, then 0110000, then 1111111, then 1111111.
  - With blank_lz = 0: digits 2 and 3 show 1000000.
- Mid-operation reset:
  - Stimulus: rst during scan index 2 at value 0x1234.
  - Required: next cycle value = 0, mux = 1110, wrap = 0.
